// File: rtl/fp_adder.sv
// ============================================================================
// Module   : fp_adder
// Purpose  : IEEE-754 binary32 adder, round-to-nearest-even, full subnormal
//            support, canonical quiet NaN, result registered (1-cycle latency,
//            one add per cycle, no handshake).
// Ports    : clk  - clock, rising edge active
//            rst  - synchronous active-high reset, clears Sum to +0
//            A, B - binary32 operands
//            Sum  - registered binary32 result of A+B
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // --------------------------------------------------------------------------
  // Unpack and classify
  // --------------------------------------------------------------------------
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  assign a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
  assign b_nan = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
  assign a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
  assign b_inf = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);

  // Zero/subnormal operands use effective exponent 1 with hidden bit 0.
  assign ea = (A[30:23] == 8'd0) ? 8'd1 : A[30:23];
  assign eb = (B[30:23] == 8'd0) ? 8'd1 : B[30:23];
  assign ma = {|A[30:23], A[22:0]};
  assign mb = {|B[30:23], B[22:0]};

  // --------------------------------------------------------------------------
  // Order by magnitude: l = larger, s = smaller
  // --------------------------------------------------------------------------
  logic        swap;
  logic        sl, ss;
  logic [7:0]  el, es;
  logic [23:0] ml, ms;

  assign swap = {eb, mb} > {ea, ma};
  assign sl   = swap ? B[31] : A[31];
  assign ss   = swap ? A[31] : B[31];
  assign el   = swap ? eb : ea;
  assign es   = swap ? ea : eb;
  assign ml   = swap ? mb : ma;
  assign ms   = swap ? ma : mb;

  // --------------------------------------------------------------------------
  // Align smaller significand: keep 24 bits + guard + round, OR the rest
  // into sticky. Distances of 26+ leave nothing but sticky.
  // --------------------------------------------------------------------------
  logic [7:0]  diff;
  logic [49:0] wide_sh;
  logic [25:0] al;
  logic        st;

  assign diff    = el - es;
  assign wide_sh = {ms, 26'd0} >> diff;
  assign al      = (diff >= 8'd26) ? 26'd0 : wide_sh[49:24];
  assign st      = (diff >= 8'd26) ? (|ms) : (|wide_sh[23:0]);

  // --------------------------------------------------------------------------
  // Add / subtract on {carry, 24-bit significand, G, R, S}.
  // Magnitude ordering guarantees the subtraction never goes negative.
  // --------------------------------------------------------------------------
  logic [27:0] x_ext, y_ext, r;
  logic        eff_sub;

  assign eff_sub = sl ^ ss;
  assign x_ext   = {1'b0, ml, 3'b000};
  assign y_ext   = {1'b0, al, st};
  assign r       = eff_sub ? (x_ext - y_ext) : (x_ext + y_ext);

  // --------------------------------------------------------------------------
  // Leading-zero count of r[26:0] (27 when r[26:0] is zero)
  // --------------------------------------------------------------------------
  logic [4:0] lz;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (r[i]) lz = 5'(26 - i);
    end
  end

  // --------------------------------------------------------------------------
  // Normalize. Left shifts are clamped so the exponent never drops below 1;
  // if the hidden bit is still clear afterwards the result is subnormal.
  // --------------------------------------------------------------------------
  logic [7:0]  lim, shamt;
  logic [26:0] n;
  logic [8:0]  e_n;

  assign lim   = el - 8'd1;
  assign shamt = ({3'b000, lz} < lim) ? {3'b000, lz} : lim;

  always_comb begin
    n   = r[26:0];
    e_n = 9'd0;
    if (r[27]) begin
      // Carry-out: the bit shifted off merges into sticky.
      n   = {r[27:2], r[1] | r[0]};
      e_n = {1'b0, el} + 9'd1;
    end else begin
      n   = r[26:0] << shamt;
      e_n = n[26] ? ({1'b0, el} - {1'b0, shamt}) : 9'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Round to nearest even. Adding the increment to the packed {exp, frac}
  // lets a fraction carry bump the exponent, including subnormal -> normal.
  // --------------------------------------------------------------------------
  logic        inc;
  logic [31:0] rounded;
  logic        ovf;

  assign inc     = n[2] & (n[1] | n[0] | n[3]);
  assign rounded = {e_n, n[25:3]} + {31'd0, inc};
  assign ovf     = rounded[31:23] >= 9'd255;

  // --------------------------------------------------------------------------
  // Result select and output register
  // --------------------------------------------------------------------------
  logic [31:0] sum_d, sum_q;

  always_comb begin
    sum_d = {sl, rounded[30:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (A[31] != B[31]))) begin
      sum_d = QNAN;
    end else if (a_inf) begin
      sum_d = A;
    end else if (b_inf) begin
      sum_d = B;
    end else if (r == 28'd0) begin
      // Exact zero is +0 unless both operands are -0.
      sum_d = {A[31] & B[31], 31'd0};
    end else if (ovf) begin
      sum_d = {sl, 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign Sum = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_adder.sv
// ============================================================================
// Module   : tb_fp_adder
// Purpose  : Self-checking bench for fp_adder. An exact-integer reference
//            model predicts Sum every cycle; directed vectors with literal
//            results pin both the model and the DUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_adder;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic [31:0] sum;

  int checks = 0;
  int errors = 0;

  fp_adder dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .Sum (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: every finite binary32 is an integer multiple of 2^-149,
  // so scale both operands by 2^149, add exactly, then round once.
  // --------------------------------------------------------------------------
  function automatic logic [299:0] to_scaled(input logic [31:0] x);
    logic [299:0] m;
    int           e;
    e = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    m = {276'd0, (x[30:23] != 8'd0), x[22:0]};
    return m << (e - 1);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic         x_nan, y_nan, x_inf, y_inf;
    logic [299:0] mx, my, mag, tmp, rem, half;
    logic         s;
    int           p, sh, ex;
    logic [24:0]  keep;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (x_nan || y_nan) return 32'h7FC0_0000;
    if (x_inf && y_inf) return (x[31] == y[31]) ? x : 32'h7FC0_0000;
    if (x_inf) return x;
    if (y_inf) return y;
    mx = to_scaled(x);
    my = to_scaled(y);
    if (x[31] == y[31]) begin
      mag = mx + my; s = x[31];
    end else if (mx >= my) begin
      mag = mx - my; s = x[31];
    end else begin
      mag = my - mx; s = y[31];
    end
    if (mag == 0) return {x[31] & y[31], 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    // Below 2^24 units the value is exact and its encoding equals the count.
    if (p <= 23) return {s, mag[30:0]};
    sh   = p - 23;
    tmp  = mag >> sh;
    keep = tmp[24:0];
    rem  = mag & ((300'd1 << sh) - 300'd1);
    half = 300'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      sh   = sh + 1;
    end
    ex = sh + 1;
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    return {s, ex[7:0], keep[22:0]};
  endfunction

  // --------------------------------------------------------------------------
  // Cycle-by-cycle compare against the model
  // --------------------------------------------------------------------------
  logic [31:0] exp_model;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    exp_model = rst ? 32'd0 : ref_add(a, b);
    chk_en    = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (sum !== exp_model) begin
        errors++;
        $display("FAIL model_cmp t=%0t Sum=%08h expected=%08h", $time, sum, exp_model);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed vectors
  // --------------------------------------------------------------------------
  localparam int NV = 17;
  logic [31:0] va [NV] = '{
    32'h3F800000, 32'h3E800000, 32'h3F800000, 32'h00000001, 32'h007FFFFF,
    32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h40000000,
    32'h80000000, 32'h7F800001, 32'hFF800000, 32'h3F800001, 32'h00800000,
    32'h4B7FFFFF, 32'h3F800000};
  logic [31:0] vb [NV] = '{
    32'h3F000000, 32'h3E000000, 32'hBF000000, 32'h00000001, 32'h00000001,
    32'h33800000, 32'h33C00000, 32'hFF800000, 32'h7F7FFFFF, 32'hC0000000,
    32'h80000000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h80000001,
    32'h3F000000, 32'h00000000};
  logic [31:0] vr [NV] = '{
    32'h3FC00000, 32'h3EC00000, 32'h3F000000, 32'h00000002, 32'h00800000,
    32'h3F800000, 32'h3F800001, 32'h7FC00000, 32'h7F800000, 32'h00000000,
    32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h34000000, 32'h007FFFFF,
    32'h4B800000, 32'h3F800000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, act, req);
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'd0;
    b   = 32'd0;

    // The model itself must reproduce the hand-computed results.
    for (int i = 0; i < NV; i++) chk($sformatf("model_vec%0d", i), ref_add(va[i], vb[i]), vr[i]);

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_value", sum, 32'd0);

    // Back-to-back directed vectors: each result appears one edge later.
    rst = 1'b0;
    a   = va[0];
    b   = vb[0];
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("dut_vec%0d", i), sum, vr[i]);
      if (i + 1 < NV) begin
        a = va[i + 1];
        b = vb[i + 1];
      end
    end

    // Pseudo-random stream, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 0) b[30:23] = a[30:23] - 8'($urandom_range(0, 3));
      if (i % 7 == 3) b[31] = ~a[31];
      @(negedge clk);
    end

    // Reset mid-stream discards the in-flight result.
    a   = 32'h3F800000;
    b   = 32'h3F800000;
    rst = 1'b1;
    @(negedge clk);
    chk("midstream_reset", sum, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset", sum, 32'h40000000);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_adder.md
# fp_adder

Single-precision (IEEE-754 binary32) floating-point adder with a registered result. It takes two operands, computes their correctly rounded sum (round-to-nearest-even), handles subnormals and special values, and presents the result one clock later. It is a leaf arithmetic block used by datapaths that need an FP32 add.

## Interface

Parameters:
- None. The format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- rst  input  1  — synchronous, active-high reset.
- A  input  32  — operand A, binary32.
- B  input  32  — operand B, binary32.
- Sum  output  32  — registered binary32 result of A+B.

## Operation

Unpacking:
- Exponent field 0 means zero or subnormal: hidden bit 0, effective exponent 1.
- Otherwise the hidden bit is 1.

Special cases, checked before the arithmetic path:
- Either operand is NaN (exp=0xFF, frac≠0) → canonical quiet NaN 0x7FC00000.
- +Inf + −Inf → 0x7FC00000.
- Exactly one operand is Inf, or both are Inf with the same sign → that Inf.

Alignment:
- Order operands by magnitude (exponent, then significand).
- Shift the smaller significand right by the exponent difference.
- Keep guard and round bits plus a sticky OR of every bit shifted out.
- Shifts of 26 or more collapse the operand into sticky.

Add/subtract:
- Same signs → add significands; otherwise subtract smaller from larger.
- Result sign is the sign of the larger-magnitude operand.

Normalize:
- On carry-out, shift right by 1 and increment the exponent; the lost bit folds into sticky.
- Otherwise shift left until the hidden bit is set, but never below effective exponent 1. A result that cannot reach the hidden bit is subnormal (exp field 0).

Round (round-to-nearest-even on guard/round/sticky):
- Increment when guard=1 and (round|sticky|lsb)=1.
- A rounding carry renormalizes: increment the exponent; a subnormal may become the smallest normal.

Overflow:
- Exponent ≥ 0xFF after rounding → signed Inf.
- Only round-to-nearest exists, so there is no saturation to the maximum finite value.

Exact zero:
- Result is +0, except (−0)+(−0) = −0.

Subnormal inputs are fully supported: no flush-to-zero, on inputs or outputs. No exception flags are produced.

## Timing

- The datapath from A/B to the internal next-sum is purely combinational, with no multicycle paths.
- Sum is a 32-bit register loaded every rising clk edge with f(A,B) from the inputs present at that edge.
- Latency is 1 cycle.
- Throughput is one add per cycle; there is no handshake and no valid signal.
- Reset: when rst=1 at a rising edge, Sum←0x00000000; this has priority over the load.
- On the first edge after rst deasserts, Sum loads the current A+B.
- Asserting reset mid-stream discards the in-flight result.
- A/B changes between edges have no effect on Sum until the next edge.

## Test plan

- Reset and basic add:
  - rst high for 2 edges → Sum=0x00000000.
  - Release rst, A=0x3F800000 (1.0), B=0x3F000000 (0.5) → Sum=0x3FC00000 (1.5) one edge later.
- Basic add and subtract:
  - A=0x3E800000 (0.25), B=0x3E000000 (0.125) → 0x3EC00000 (0.375).
  - A=0x3F800000, B=0xBF000000 (−0.5) → 0x3F000000.
- Subnormals:
  - A=0x00000001, B=0x00000001 → 0x00000002.
  - A=0x007FFFFF, B=0x00000001 → 0x00800000 (subnormal to normal).
- Rounding:
  - A=0x3F800000, B=0x33800000 (2^-24, tie) → 0x3F800000 (tie to even).
  - A=0x3F800000, B=0x33C00000 → 0x3F800001 (above half rounds up).
- Specials:
  - A=0x7F800000, B=0xFF800000 → 0x7FC00000.
  - A=0x7F7FFFFF, B=0x7F7FFFFF → 0x7F800000.
  - A=0x40000000, B=0xC0000000 → 0x00000000.
  - A=0x80000000, B=0x80000000 → 0x80000000.
- Pipelining:
  - Apply a new operand pair every cycle → each Sum equals the pair applied one edge earlier.
  - Reset asserted mid-stream → Sum=0 on that edge.
